// File: rtl/hqm_iosf_hs_src_driver_if.sv
// Source-side view of the level-valid/pulse-ready handshake: held request level,
// its data word, and the one-cycle completion pulse returned by the partner.
interface hqm_iosf_hs_src_driver_if #(
    parameter int WIDTH = 32
);
    logic             val_src;
    logic [WIDTH-1:0] dat_src;
    logic             rdy_src;

    modport master (
        output val_src,
        output dat_src,
        input  rdy_src
    );

    modport slave (
        input  val_src,
        input  dat_src,
        output rdy_src
    );
endinterface

// File: rtl/hqm_iosf_hs_src_driver.sv
// Source-domain driver: queues a valid/ready stream and presents one entry at a
// time as a held val_src level, retiring it on the rdy_src pulse.
module hqm_iosf_hs_src_driver #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    hqm_iosf_hs_src_driver_if.master hs,
    input  logic                     err_clr,
    output logic                     err_timeout,
    output logic                     err_spurious,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [15:0]              xfer_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TW-1:0]    to_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             val_q;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic timeout_hit;
    logic spurious_hit;

    assign in_ready     = (fifo_cnt != CW'(DEPTH));
    assign push         = in_valid && in_ready;
    assign pop          = (state == ST_REQ) && hs.rdy_src;
    assign timeout_hit  = (state == ST_REQ) && !hs.rdy_src && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign spurious_hit = (state != ST_REQ) && hs.rdy_src;

    assign hs.val_src = val_q;
    assign hs.dat_src = dat_q;

    // NOTE: storage has no reset; occupancy and pointers alone define validity,
    // and leaving it out keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // NOTE: every sequential assignment is non-blocking so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            xfer_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (pop) xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    // The request is never abandoned once raised: the partner may already be
    // carrying it across the clock boundary, so timeout only flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            val_q   <= 1'b0;
            dat_q   <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (fifo_cnt != '0) begin
                        state <= ST_REQ;
                        val_q <= 1'b1;
                        dat_q <= mem[rd_ptr];
                    end
                end
                ST_REQ: begin
                    if (hs.rdy_src) begin
                        state   <= ST_GAP;
                        val_q   <= 1'b0;
                        to_cnt  <= '0;
                        gap_cnt <= '0;
                    end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) state <= ST_IDLE;
                    else                              gap_cnt <= gap_cnt + GW'(1);
                end
                default: begin
                    state <= ST_IDLE;
                    val_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a setting event in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (timeout_hit)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
            if (spurious_hit) err_spurious <= 1'b1;
            else if (err_clr) err_spurious <= 1'b0;
        end
    end
endmodule
